// File: rtl/sb_pkg.sv
// Shared defaults and sizing helper for the scoreboard register file.
package sb_pkg;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_NREG    = 32;
  localparam int DEF_NRD     = 2;
  localparam int DEF_MAXPEND = 3;

  // Bits needed to hold a pending count in 0..maxpend.
  function automatic int cnt_width(input int maxpend);
    return (maxpend < 1) ? 1 : $clog2(maxpend + 1);
  endfunction
endpackage

// File: rtl/scoreboard_regfile_if.sv
// Read, issue, writeback and flush bundle between decode/writeback and the scoreboard.
interface scoreboard_regfile_if import sb_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD
) ();
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                issue_valid;
  logic [AW-1:0]       issue_dest;
  logic                issue_ready;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic                err_underflow;

  modport master (
    output raddr, issue_valid, issue_dest, wb_we, wb_addr, wb_data, flush,
    input  rdata, rbusy, issue_ready, err_underflow
  );

  modport slave (
    input  raddr, issue_valid, issue_dest, wb_we, wb_addr, wb_data, flush,
    output rdata, rbusy, issue_ready, err_underflow
  );
endinterface

// File: rtl/sb_counter.sv
// Saturating pending-writer counter; clr wins, inc+dec together hold.
module sb_counter #(
  parameter int CW  = 2,
  parameter int MAX = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] MAXV = CW'(MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              cnt <= '0;
    else if (clr)                             cnt <= '0;
    else if (inc && !dec && cnt != MAXV)      cnt <= cnt + CW'(1);
    else if (dec && !inc && cnt != '0)        cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-writer tracking, write-through reads
// and issue back-pressure when a destination already has MAXPEND writers.
module scoreboard_regfile import sb_pkg::*; #(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int NRD     = DEF_NRD,
  parameter int MAXPEND = DEF_MAXPEND
) (
  input logic                 clk,
  input logic                 resetn,
  scoreboard_regfile_if.slave sb
);
  localparam int AW = $clog2(NREG);
  localparam int CW = cnt_width(MAXPEND);
  localparam logic [CW-1:0] MAXV = CW'(MAXPEND);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [CW-1:0]             cnt [NREG];
  logic                      wb_live;
  logic                      fire;
  logic                      err_q;

  assign wb_live = sb.wb_we && (sb.wb_addr != '0);

  // A same-cycle writeback to the destination frees a slot, so it can accept.
  assign sb.issue_ready = !sb.flush &&
                          ((sb.issue_dest == '0) || (cnt[sb.issue_dest] < MAXV) ||
                           (sb.wb_we && (sb.wb_addr == sb.issue_dest)));
  assign fire = sb.issue_valid && sb.issue_ready;

  assign cnt[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CW(CW), .MAX(MAXPEND)) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (fire && (sb.issue_dest == AW'(r))),
      .dec    (sb.wb_we && (sb.wb_addr == AW'(r))),
      .clr    (sb.flush),
      .cnt    (cnt[r])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      regs <= '0;
    else if (wb_live) regs[sb.wb_addr] <= sb.wb_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 err_q <= 1'b0;
    else if (wb_live && cnt[sb.wb_addr] == '0)   err_q <= 1'b1;
  end
  assign sb.err_underflow = err_q;

  logic [NRD-1:0][XLEN-1:0] rdata_l;
  logic [NRD-1:0]           rbusy_l;
  logic [AW-1:0]            ra;
  logic                     hit;

  // Busy means some writer is still outstanding after this cycle's writeback.
  always_comb begin
    rdata_l = '0;
    rbusy_l = '0;
    ra      = '0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra         = sb.raddr[i*AW +: AW];
      hit        = sb.wb_we && (sb.wb_addr == ra) && (ra != '0);
      rdata_l[i] = hit ? sb.wb_data : regs[ra];
      rbusy_l[i] = (ra != '0) && (cnt[ra] != '0) && !(hit && cnt[ra] == CW'(1));
    end
  end

  assign sb.rdata = rdata_l;
  assign sb.rbusy = rbusy_l;
endmodule
